// File: rtl/board_draw_ctrl_if.sv
// Drawer-side bus of board_draw_ctrl: symbol command, completion and gated plot.
// Handshake: the controller raises sym_go for exactly one cycle with sym_x, sym_y
// and sym_sel already valid; the drawer answers with a one-cycle sym_done. Only
// one command is ever outstanding, and sym_x/sym_y/sym_sel hold their values until
// that sym_done has been taken. plot is plot_in passed through only while a
// command is outstanding.
interface board_draw_ctrl_if;
  logic [7:0] sym_x;
  logic [6:0] sym_y;
  logic [1:0] sym_sel;
  logic       sym_go;
  logic       sym_done;
  logic       plot_in;
  logic       plot;

  modport master (
    output sym_x, sym_y, sym_sel, sym_go, plot,
    input  sym_done, plot_in
  );

  modport slave (
    input  sym_x, sym_y, sym_sel, sym_go, plot,
    output sym_done, plot_in
  );
endinterface

// File: rtl/board_draw_ctrl.sv
// Redraw sequencer for a 3x3 board: holds the board and one dirty bit per cell,
// walks dirty cells round-robin and commands the symbol drawer to erase each cell
// and, when occupied, draw its symbol. A watchdog abandons a hung draw and raises
// a sticky err flag.
module board_draw_ctrl #(
  parameter logic [7:0] X0      = 8'd40,
  parameter logic [6:0] Y0      = 7'd20,
  parameter logic [4:0] PITCH   = 5'd20,
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        cell_wr,
  input  logic [3:0]  cell_idx,
  input  logic [1:0]  cell_val,
  output logic [17:0] board,
  output logic        busy,
  output logic        frame_done,
  output logic        err,
  output logic [2:0]  dbg_state,
  board_draw_ctrl_if.master drw
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SCAN  = 3'd1;
  localparam logic [2:0] S_EGO   = 3'd2;
  localparam logic [2:0] S_EWAIT = 3'd3;
  localparam logic [2:0] S_DGO   = 3'd4;
  localparam logic [2:0] S_DWAIT = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]  state;
  logic [3:0]  ptr;
  logic [3:0]  clean_cnt;
  logic [3:0]  cur_idx;
  logic [1:0]  cur_val;
  logic [7:0]  wd;
  logic [8:0]  dirty;
  logic [8:0]  dirty_nxt;
  logic [17:0] board_nxt;
  logic [7:0]  sym_x_q;
  logic [6:0]  sym_y_q;
  logic [1:0]  sym_sel_q;
  logic        sym_go_q;

  logic        in_wait;
  logic        dirty_at_ptr;
  logic        scan_hit;
  logic        wd_expire;
  logic        wr_ok;
  logic        wr_change;
  logic [1:0]  board_at_ptr;
  logic [1:0]  board_at_wr;
  logic [1:0]  row;
  logic [1:0]  col;
  logic [7:0]  org_x;
  logic [6:0]  org_y;

  // Round-robin successor of a cell index, 8 wraps to 0.
  function automatic logic [3:0] next_idx(input logic [3:0] i);
    return (i >= 4'd8) ? 4'd0 : i + 4'd1;
  endfunction

  assign in_wait   = (state == S_EWAIT) || (state == S_DWAIT);
  assign scan_hit  = (state == S_SCAN) && dirty_at_ptr;
  // wd counts cycles since sym_go, so expiry at TIMEOUT-1 makes err visible
  // exactly TIMEOUT cycles after the sym_go cycle.
  assign wd_expire = in_wait && !drw.sym_done && (wd == TIMEOUT - 8'd1);
  assign wr_ok     = cell_wr && (cell_idx <= 4'd8) && (cell_val != 2'b11);
  assign wr_change = wr_ok && (board_at_wr != cell_val);

  // Per-cell lookups of the scan pointer and the write index.
  always_comb begin
    dirty_at_ptr = 1'b0;
    board_at_ptr = 2'b00;
    board_at_wr  = 2'b00;
    for (int k = 0; k < 9; k++) begin
      if (ptr == 4'(k)) begin
        dirty_at_ptr = dirty[k];
        board_at_ptr = board[2*k +: 2];
      end
      if (cell_idx == 4'(k)) begin
        board_at_wr = board[2*k +: 2];
      end
    end
  end

  // Pixel origin of the cell under the scan pointer.
  always_comb begin
    case (ptr)
      4'd0, 4'd1, 4'd2: row = 2'd0;
      4'd3, 4'd4, 4'd5: row = 2'd1;
      default:          row = 2'd2;
    endcase
    case (ptr)
      4'd0, 4'd3, 4'd6: col = 2'd0;
      4'd1, 4'd4, 4'd7: col = 2'd1;
      default:          col = 2'd2;
    endcase
    org_x = X0 + ({6'b0, col} * {3'b0, PITCH});
    org_y = Y0 + ({5'b0, row} * {2'b0, PITCH});
  end

  // Next board and dirty vector; a write's dirty set overrides the scan clear.
  always_comb begin
    dirty_nxt = dirty;
    board_nxt = board;
    for (int k = 0; k < 9; k++) begin
      if (scan_hit && (ptr == 4'(k))) dirty_nxt[k] = 1'b0;
      if (start) dirty_nxt[k] = 1'b1;
      if (wr_ok && (cell_idx == 4'(k))) begin
        board_nxt[2*k +: 2] = cell_val;
        if (wr_change) dirty_nxt[k] = 1'b1;
      end
    end
  end

  // Board, dirty bits and the sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      board <= '0;
      dirty <= '0;
      err   <= 1'b0;
    end else begin
      board <= board_nxt;
      dirty <= dirty_nxt;
      if (start) begin
        err <= 1'b0;
      end else if (wd_expire) begin
        err <= 1'b1;
      end
    end
  end

  // Sequencer: scan, erase, optional draw, watchdog, with registered drawer command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= 4'd0;
      clean_cnt <= 4'd0;
      cur_idx   <= 4'd0;
      cur_val   <= 2'b00;
      wd        <= 8'd0;
      sym_x_q   <= 8'd0;
      sym_y_q   <= 7'd0;
      sym_sel_q <= 2'b00;
      sym_go_q  <= 1'b0;
    end else begin
      sym_go_q <= 1'b0;
      case (state)
        S_IDLE: begin
          clean_cnt <= 4'd0;
          if (|dirty) state <= S_SCAN;
        end
        S_SCAN: begin
          if (dirty_at_ptr) begin
            cur_idx   <= ptr;
            cur_val   <= board_at_ptr;
            sym_x_q   <= org_x;
            sym_y_q   <= org_y;
            sym_sel_q <= 2'b00;
            sym_go_q  <= 1'b1;
            state     <= S_EGO;
          end else begin
            ptr       <= next_idx(ptr);
            clean_cnt <= clean_cnt + 4'd1;
            if (clean_cnt == 4'd8) state <= S_DONE;
          end
        end
        S_EGO: begin
          wd    <= 8'd1;
          state <= S_EWAIT;
        end
        S_EWAIT: begin
          if (drw.sym_done) begin
            if (cur_val != 2'b00) begin
              sym_sel_q <= cur_val;
              sym_go_q  <= 1'b1;
              state     <= S_DGO;
            end else begin
              ptr       <= next_idx(cur_idx);
              clean_cnt <= 4'd0;
              state     <= S_SCAN;
            end
          end else if (wd_expire) begin
            ptr       <= next_idx(cur_idx);
            clean_cnt <= 4'd0;
            state     <= S_SCAN;
          end else begin
            wd <= wd + 8'd1;
          end
        end
        S_DGO: begin
          wd    <= 8'd1;
          state <= S_DWAIT;
        end
        S_DWAIT: begin
          if (drw.sym_done || wd_expire) begin
            ptr       <= next_idx(cur_idx);
            clean_cnt <= 4'd0;
            state     <= S_SCAN;
          end else begin
            wd <= wd + 8'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = (state != S_IDLE);
  assign frame_done  = (state == S_DONE);
  assign dbg_state   = state;
  assign drw.sym_x   = sym_x_q;
  assign drw.sym_y   = sym_y_q;
  assign drw.sym_sel = sym_sel_q;
  assign drw.sym_go  = sym_go_q;
  // Combinational so that an asynchronous reset of state drops plot at once.
  assign drw.plot    = drw.plot_in & in_wait;

endmodule

// File: tb/tb_board_draw_ctrl.sv
// Bench for board_draw_ctrl: acts as the symbol drawer, predicts every drawer
// command from a round-robin board model and checks frame completion, timeout,
// plot gating and reset behaviour.
module tb_board_draw_ctrl;

  localparam int TIMEOUT_CYC = 255;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start;
  logic        cell_wr;
  logic [3:0]  cell_idx;
  logic [1:0]  cell_val;
  logic [17:0] board;
  logic        busy;
  logic        frame_done;
  logic        err;
  logic [2:0]  dbg_state;

  board_draw_ctrl_if drw_if();

  board_draw_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cell_wr    (cell_wr),
    .cell_idx   (cell_idx),
    .cell_val   (cell_val),
    .board      (board),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err),
    .dbg_state  (dbg_state),
    .drw        (drw_if)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [16:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_board[9];
  bit m_dirty[9];
  int m_ptr;
  bit m_err;

  function automatic logic [7:0] ox(input int i);
    return 8'(40 + (i % 3) * 20);
  endfunction

  function automatic logic [6:0] oy(input int i);
    return 7'(20 + (i / 3) * 20);
  endfunction

  function automatic logic [17:0] m_pack();
    logic [17:0] b;
    b = '0;
    for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(m_board[i]);
    return b;
  endfunction

  // First dirty cell at or after the round-robin pointer, -1 if none.
  function automatic int pick();
    for (int k = 0; k < 9; k++) begin
      if (m_dirty[(m_ptr + k) % 9]) return (m_ptr + k) % 9;
    end
    return -1;
  endfunction

  function automatic void model_write(input int idx, input int val);
    if (idx <= 8 && val != 3 && m_board[idx] != val) begin
      m_board[idx] = val;
      m_dirty[idx] = 1'b1;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 9; i++) begin
      m_board[i] = 0;
      m_dirty[i] = 1'b0;
    end
    m_ptr = 0;
    m_err = 1'b0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_write(input int idx, input int val);
    @(negedge clk);
    start    = 1'b0;
    cell_wr  = 1'b1;
    cell_idx = 4'(idx);
    cell_val = 2'(val);
    model_write(idx, val);
  endtask

  task automatic do_start();
    @(negedge clk);
    cell_wr = 1'b0;
    start   = 1'b1;
    for (int i = 0; i < 9; i++) m_dirty[i] = 1'b1;
    m_err = 1'b0;
  endtask

  // Wait (bounded) for sym_go; plot must stay gated off meanwhile.
  task automatic wait_go(output int cyc);
    cyc = 0;
    while (cyc < 60) begin
      @(negedge clk);
      start           = 1'b0;
      cell_wr         = 1'b0;
      drw_if.sym_done = 1'b0;
      drw_if.plot_in  = 1'b1;
      cyc++;
      #1;
      check_val("plot_gated", {31'b0, drw_if.plot}, 0);
      if (drw_if.sym_go) break;
    end
    drw_if.plot_in = 1'b0;
    if (!drw_if.sym_go) check_val("go_seen", 0, 1);
  endtask

  // Drawer response: optional write in flight, plot pass-through, sym_done after delay.
  task automatic respond(input int delay, input bit do_wr, input int widx, input int wval);
    for (int c = 1; c < delay; c++) begin
      @(negedge clk);
      cell_wr        = 1'b0;
      drw_if.plot_in = 1'b0;
      if (do_wr && c == 1) begin
        cell_wr  = 1'b1;
        cell_idx = 4'(widx);
        cell_val = 2'(wval);
        model_write(widx, wval);
      end
      if (c == 2) begin
        drw_if.plot_in = 1'b1;
        #1;
        check_val("plot_wait", {31'b0, drw_if.plot}, 1);
      end
    end
    @(negedge clk);
    cell_wr         = 1'b0;
    drw_if.plot_in  = 1'b0;
    drw_if.sym_done = 1'b1;
  endtask

  // Serve every predicted drawer command until the pass ends, then check frame_done.
  task automatic serve_all(input int delay, input int hook_cell, input int hook_ph,
                           input int widx, input int wval, input int hold_cell,
                           input bit chk_lat);
    int i;
    int cur_val;
    int cyc;
    bit first;
    bit worked;
    bit seen;
    logic [16:0] e;
    logic [16:0] o;
    first  = chk_lat;
    worked = 1'b0;
    for (i = pick(); i >= 0; i = pick()) begin
      worked = 1'b1;
      for (int ph = 0; ph < 2; ph++) begin
        if (ph == 0) begin
          e = {2'b00, ox(i), oy(i)};
          m_dirty[i] = 1'b0;
          cur_val = m_board[i];
        end else begin
          if (cur_val == 0) break;
          e = {2'(cur_val), ox(i), oy(i)};
        end
        exp_q.push_back(e);
        wait_go(cyc);
        if (first) begin
          check_val("start_latency", cyc, 3);
          first = 1'b0;
        end
        o = {drw_if.sym_sel, drw_if.sym_x, drw_if.sym_y};
        if (ph == 0) check_val("erase_op", {15'b0, o}, {15'b0, exp_q.pop_front()});
        else         check_val("draw_op", {15'b0, o}, {15'b0, exp_q.pop_front()});
        if (ph == 0 && i == hold_cell) begin
          cyc = 0;
          while (cyc < 300 && !err) begin
            @(negedge clk);
            cyc++;
          end
          check_val("timeout_cycles", cyc, TIMEOUT_CYC);
          m_err = 1'b1;
          hold_cell = -1;
          break;
        end
        respond(delay, (i == hook_cell && ph == hook_ph), widx, wval);
        if (i == hook_cell && ph == hook_ph) hook_cell = -1;
      end
      m_ptr = (i + 1) % 9;
    end
    if (worked) begin
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        @(negedge clk);
        drw_if.sym_done = 1'b0;
        cell_wr         = 1'b0;
        start           = 1'b0;
        drw_if.plot_in  = 1'b1;
        #1;
        check_val("plot_gated", {31'b0, drw_if.plot}, 0);
        seen = frame_done;
      end
      drw_if.plot_in = 1'b0;
      check_val("frame_done", {31'b0, seen}, 1);
    end else begin
      repeat (4) @(negedge clk);
      cell_wr = 1'b0;
    end
    @(negedge clk);
    check_val("idle_after_pass", {31'b0, busy}, 0);
    check_val("board", {14'b0, board}, {14'b0, m_pack()});
    check_val("err", {31'b0, err}, {31'b0, m_err});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    reset           = 1'b1;
    start           = 1'b0;
    cell_wr         = 1'b0;
    cell_idx        = 4'd0;
    cell_val        = 2'b00;
    drw_if.sym_done = 1'b0;
    drw_if.plot_in  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_board", {14'b0, board}, 0);
    check_val("rst_busy", {31'b0, busy}, 0);
    check_val("rst_err", {31'b0, err}, 0);
    check_val("rst_frame_done", {31'b0, frame_done}, 0);
    check_val("rst_sym", {14'b0, drw_if.sym_go, drw_if.sym_sel, drw_if.sym_x, drw_if.sym_y}, 0);
    check_val("rst_plot", {31'b0, drw_if.plot}, 0);

    // Full redraw after reset: nine erases in index order, sym_done 34 cycles after sym_go.
    do_start();
    serve_all(34, -1, 0, 0, 0, -1, 1'b1);

    // Single X at cell 4, then a repeated identical write that must stay quiet.
    do_write(4, 1);
    serve_all(10, -1, 0, 0, 0, -1, 1'b0);
    do_write(4, 1);
    repeat (6) @(negedge clk);
    cell_wr = 1'b0;
    check_val("repeat_write_idle", {31'b0, busy}, 0);
    check_val("repeat_write_board", {14'b0, board}, {14'b0, m_pack()});

    // Cell 2 written while cell 7 draws: 7 completes, then 2 via round-robin.
    do_write(7, 1);
    serve_all(12, 7, 1, 2, 2, -1, 1'b0);

    // Cell 4 rewritten during its own draw: a second erase and draw follow.
    do_write(4, 2);
    serve_all(12, 4, 1, 4, 1, -1, 1'b0);

    // Illegal writes are ignored.
    do_write(9, 1);
    do_write(3, 3);
    repeat (6) @(negedge clk);
    cell_wr = 1'b0;
    check_val("bad_write_idle", {31'b0, busy}, 0);
    check_val("bad_write_board", {14'b0, board}, {14'b0, m_pack()});

    // Withheld sym_done: timeout on cell 1, service moves on, start then clears err.
    do_write(1, 1);
    do_write(5, 2);
    serve_all(8, -1, 0, 0, 0, 1, 1'b0);
    do_start();
    serve_all(6, -1, 0, 0, 0, -1, 1'b1);

    // Randomised frames.
    for (int f = 0; f < 8; f++) begin
      int nw;
      nw = $urandom_range(1, 2);
      for (int w = 0; w < nw; w++) begin
        int ri;
        int rv;
        ri = ($urandom_range(0, 9) == 0) ? 9 : $urandom_range(0, 8);
        rv = $urandom_range(0, 3);
        do_write(ri, rv);
      end
      serve_all($urandom_range(4, 40), $urandom_range(0, 8), $urandom_range(0, 1),
                $urandom_range(0, 8), $urandom_range(0, 2), -1, 1'b0);
    end

    // plot_in while idle stays gated.
    @(negedge clk);
    drw_if.plot_in = 1'b1;
    #1;
    check_val("plot_idle", {31'b0, drw_if.plot}, 0);
    drw_if.plot_in = 1'b0;

    // Reset asserted mid-erase clears everything at once.
    do_write(0, 2);
    if (m_board[0] != 2) begin
      do_write(0, 1);
    end
    wait_go(cyc);
    repeat (3) @(negedge clk);
    drw_if.plot_in = 1'b1;
    #1;
    check_val("plot_before_reset", {31'b0, drw_if.plot}, 1);
    #2;
    reset = 1'b1;
    #1;
    check_val("async_plot", {31'b0, drw_if.plot}, 0);
    check_val("async_busy", {31'b0, busy}, 0);
    check_val("async_board", {14'b0, board}, 0);
    check_val("async_sym", {14'b0, drw_if.sym_go, drw_if.sym_sel, drw_if.sym_x, drw_if.sym_y}, 0);
    check_val("async_state", {29'b0, dbg_state}, 0);
    @(negedge clk);
    reset          = 1'b0;
    drw_if.plot_in = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    check_val("no_auto_draw", {31'b0, busy}, 0);
    check_val("post_reset_err", {31'b0, err}, 0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #900000;
    $display("FAIL watchdog: observed run still active, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
